serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 80 ++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first.
// Reports the modular difference, the unsigned borrow and the signed overflow.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] ra, rb;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             ai, bi, d, br_nxt;

   always_comb begin
      ai     = ra[cnt];
      bi     = rb[cnt];
      d      = ai ^ bi ^ br;
      br_nxt = (~ai & bi) | (~(ai ^ bi) & br);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ra     <= '0;
         rb     <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ra    <= a;
                  rb    <= b;
                  br    <= 1'b0;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
               diff <= {d, diff[WIDTH-1:1]};
               br   <= br_nxt;
               if (cnt == LAST) begin
                  state  <= DONE;
                  borrow <= br_nxt;
                  ovf    <= (ra[WIDTH-1] ^ rb[WIDTH-1]) & (d ^ ra[WIDTH-1]);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule
